// File: rtl/vip_rgb_wb_gain.sv
// Per-channel white-balance gain with frame-synchronous gain shadowing and
// per-frame pre-gain R/G/B sum and pixel-count statistics.
module vip_rgb_wb_gain #(
  parameter int DATA_W    = 8,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int SUM_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GAIN_W-1:0] cfg_gain_r,
  input  logic [GAIN_W-1:0] cfg_gain_g,
  input  logic [GAIN_W-1:0] cfg_gain_b,
  input  logic              cfg_update,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_href,
  input  logic [DATA_W-1:0] pre_img_red,
  input  logic [DATA_W-1:0] pre_img_green,
  input  logic [DATA_W-1:0] pre_img_blue,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic [DATA_W-1:0] post_img_red,
  output logic [DATA_W-1:0] post_img_green,
  output logic [DATA_W-1:0] post_img_blue,
  output logic [SUM_W-1:0]  stat_sum_r,
  output logic [SUM_W-1:0]  stat_sum_g,
  output logic [SUM_W-1:0]  stat_sum_b,
  output logic [SUM_W-1:0]  stat_pix_cnt,
  output logic              stat_valid
);
  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int RND_W  = PROD_W + 1 - GAIN_FRAC;
  localparam logic [GAIN_W-1:0] UNITY     = GAIN_W'(1) << GAIN_FRAC;
  localparam logic [PROD_W:0]   HALF      = (PROD_W+1)'(1) << (GAIN_FRAC - 1);
  localparam logic [RND_W-1:0]  PIX_MAX   = RND_W'({DATA_W{1'b1}});
  localparam logic [DATA_W-1:0] PIX_MAX_D = '1;

  logic                     vsync_d_q;
  logic                     frame_start;
  logic                     frame_end;
  logic                     counted;
  logic                     armed_q;
  logic                     stat_valid_q;
  logic                     pend_flag_q;
  logic [2:0][GAIN_W-1:0]   cfg_gain;
  logic [2:0][GAIN_W-1:0]   active_q;
  logic [2:0][GAIN_W-1:0]   pending_q;
  logic [2:0][GAIN_W-1:0]   gain_eff;
  logic [2:0][DATA_W-1:0]   pix;
  logic [2:0][DATA_W-1:0]   out_all;
  logic [3:0][DATA_W-1:0]   stat_in;
  logic [3:0][SUM_W-1:0]    stat_all;
  logic [2:0]               vs_pipe_q;
  logic [2:0]               hr_pipe_q;

  assign frame_start = pre_frame_vsync & ~vsync_d_q;
  assign frame_end   = ~pre_frame_vsync & vsync_d_q;
  assign counted     = pre_frame_vsync & pre_frame_href;
  assign cfg_gain    = {cfg_gain_b, cfg_gain_g, cfg_gain_r};
  assign pix         = {pre_img_blue, pre_img_green, pre_img_red};
  // Lane 3 accumulates a constant 1 per counted pixel, giving the pixel count.
  assign stat_in     = {DATA_W'(1), pre_img_blue, pre_img_green, pre_img_red};

  // A pixel arriving on the frame_start cycle already belongs to the new frame,
  // so it must see the gains being promoted on that same edge.
  assign gain_eff = (frame_start && pend_flag_q) ? pending_q : active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_q    <= 1'b0;
      armed_q      <= 1'b0;
      stat_valid_q <= 1'b0;
      active_q     <= {3{UNITY}};
      pending_q    <= {3{UNITY}};
      pend_flag_q  <= 1'b0;
      vs_pipe_q    <= '0;
      hr_pipe_q    <= '0;
    end else begin
      vsync_d_q    <= pre_frame_vsync;
      stat_valid_q <= frame_end & armed_q;
      if (frame_start) armed_q <= 1'b1;
      if (frame_start && pend_flag_q) begin
        active_q    <= pending_q;
        pend_flag_q <= 1'b0;
      end
      if (cfg_update) begin
        pending_q   <= cfg_gain;
        pend_flag_q <= 1'b1;
      end
      vs_pipe_q <= {vs_pipe_q[1:0], pre_frame_vsync};
      hr_pipe_q <= {hr_pipe_q[1:0], pre_frame_href};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [PROD_W-1:0] prod_q;
      logic [RND_W-1:0]  rnd_q;
      logic [DATA_W-1:0] out_q;
      logic [PROD_W:0]   rnd_sum;
      logic [DATA_W-1:0] sat_val;

      assign rnd_sum = {1'b0, prod_q} + HALF;
      assign sat_val = (rnd_q > PIX_MAX) ? PIX_MAX_D : rnd_q[DATA_W-1:0];

      always_ff @(posedge clk) begin
        if (rst) begin
          prod_q <= '0;
          rnd_q  <= '0;
          out_q  <= '0;
        end else begin
          prod_q <= PROD_W'(pix[gi]) * PROD_W'(gain_eff[gi]);
          rnd_q  <= rnd_sum[PROD_W:GAIN_FRAC];
          out_q  <= (vs_pipe_q[1] & hr_pipe_q[1]) ? sat_val : '0;
        end
      end
      assign out_all[gi] = out_q;
    end

    for (gi = 0; gi < 4; gi++) begin : g_stat
      logic [SUM_W-1:0] acc_q;
      logic [SUM_W-1:0] acc_d;
      logic [SUM_W-1:0] stat_q;
      logic [SUM_W:0]   acc_add;

      assign acc_add = {1'b0, acc_q} + (SUM_W+1)'(stat_in[gi]);

      always_comb begin
        acc_d = acc_q;
        if (frame_start)    acc_d = counted ? SUM_W'(stat_in[gi]) : '0;
        else if (frame_end) acc_d = '0;
        else if (counted)   acc_d = acc_add[SUM_W] ? '1 : acc_add[SUM_W-1:0];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q  <= '0;
          stat_q <= '0;
        end else begin
          acc_q <= acc_d;
          if (frame_end && armed_q) stat_q <= acc_q;
        end
      end
      assign stat_all[gi] = stat_q;
    end
  endgenerate

  assign post_frame_vsync = vs_pipe_q[2];
  assign post_frame_href  = hr_pipe_q[2];
  assign post_img_red     = out_all[0];
  assign post_img_green   = out_all[1];
  assign post_img_blue    = out_all[2];
  assign stat_sum_r       = stat_all[0];
  assign stat_sum_g       = stat_all[1];
  assign stat_sum_b       = stat_all[2];
  assign stat_pix_cnt     = stat_all[3];
  assign stat_valid       = stat_valid_q;
endmodule
